// File: rtl/store_trace_fifo.sv
// Snoops core stores into a first-word-fall-through FIFO drained by valid/ready, plus a sticky pass/fail checker.
// Push-to-visible and checker latency 1 cycle; when full, stores are dropped (sticky overflow) unless a pop frees the slot on the same edge.
module store_trace_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] IGNORE_ADDR = 32'd80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_write,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              write_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     pass,
  output logic                     fail,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  chk_state_t    state;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;

  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign do_pop  = !empty && out_ready;
  assign do_push = mem_write && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
      if (mem_write && !do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible unless count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{addr: data_addr, data: write_data};
  end

  assign head     = empty ? '0 : mem[rd_ptr];
  assign out_addr = head.addr;
  assign out_data = head.data;

  // Case equality so X/Z on the bus resolves as a mismatch, never as a pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else if (state == ST_RUN && mem_write) begin
      if ((data_addr === PASS_ADDR) && (write_data === PASS_DATA))
        state <= ST_PASS;
      else if (data_addr !== IGNORE_ADDR)
        state <= ST_FAIL;
    end
  end

  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);
  assign done = pass | fail;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Bench for store_trace_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_store_trace_fifo;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        full, empty, overflow, pass, fail, done;

  int n_checks = 0;
  int n_fail   = 0;

  store_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_addr(data_addr),
    .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .pass(pass), .fail(fail), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of entries and a three-valued verdict.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  bit   m_ovf   = 1'b0;
  int   m_state = 0; // 0 running, 1 passed, 2 failed

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_state = 0;
    end else begin
      int  sz;
      bit  pop, acc;
      sz  = q.size();
      pop = (sz > 0) && out_ready;
      acc = mem_write && ((sz < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{a: data_addr, d: write_data});
      if (mem_write && !acc) m_ovf = 1'b1;
      if (mem_write && m_state == 0) begin
        if (data_addr === 32'd84 && write_data === 32'd7) m_state = 1;
        else if (data_addr !== 32'd80) m_state = 2;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, ed;
    ea = (q.size() > 0) ? q[0].a : 32'd0;
    ed = (q.size() > 0) ? q[0].d : 32'd0;
    chk("model_count",     32'(count),     32'(q.size()));
    chk("model_empty",     32'(empty),     32'(q.size() == 0));
    chk("model_full",      32'(full),      32'(q.size() == DEPTH));
    chk("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("model_out_addr",  out_addr,       ea);
    chk("model_out_data",  out_data,       ed);
    chk("model_overflow",  32'(overflow),  32'(m_ovf));
    chk("model_pass",      32'(pass),      32'(m_state == 1));
    chk("model_fail",      32'(fail),      32'(m_state == 2));
    chk("model_done",      32'(done),      32'(m_state != 0));
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    mem_write  = 1'b1;
    data_addr  = a;
    write_data = d;
    out_ready  = rdy;
    @(posedge clk); #1;
    mem_write = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    mem_write = 1'b0;
    out_ready = rdy;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    logic [31:0] ra, rd;
    int          sel;
    exp_a = '{32'd80, 32'd84, 32'd100};
    exp_d = '{32'd5, 32'd7, 32'd1};
    reset = 1'b0; mem_write = 1'b0; data_addr = '0; write_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_done",  32'(done),  32'd0);
    reset = 1'b1;

    // Ordered capture, pass detection, drain.
    store(32'd80, 32'd5, 1'b0);
    chk("t1_pass_before", 32'(pass), 32'd0);
    store(32'd84, 32'd7, 1'b0);
    chk("t1_pass_set", 32'(pass), 32'd1);
    store(32'd100, 32'd1, 1'b0);
    chk("t1_pass_sticky", 32'(pass), 32'd1);
    chk("t1_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_drain_addr", out_addr, exp_a[i]);
      chk("t1_drain_data", out_data, exp_d[i]);
      idle(1'b1);
    end
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_head_zero", out_addr, 32'd0);

    // Wrong data at the pass address is a failure, and it is terminal.
    do_reset();
    store(32'd84, 32'd6, 1'b0);
    chk("t2_fail", 32'(fail), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
    store(32'd84, 32'd7, 1'b0);
    chk("t2_fail_sticky", 32'(fail), 32'd1);
    chk("t2_pass_stays0", 32'(pass), 32'd0);

    // Overflow drops the ninth store.
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(32'(200 + i), 32'(i), 1'b0);
    store(32'd300, 32'd9, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_drain_addr", out_addr, 32'(200 + i));
      idle(1'b1);
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // Full plus simultaneous pop accepts the store.
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(32'(200 + i), 32'(i), 1'b0);
    store(32'd300, 32'd9, 1'b1);
    chk("t3b_overflow", 32'(overflow), 32'd0);
    chk("t3b_count", 32'(count), 32'd8);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("t3b_drain_addr", out_addr, (i == DEPTH) ? 32'd300 : 32'(200 + i));
      idle(1'b1);
    end

    // Streaming push+pop across pointer wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      store(32'(i), 32'(i * 3), 1'b1);
      chk("t4_count", 32'(count), 32'd1);
      chk("t4_head_addr", out_addr, 32'(i));
      chk("t4_head_data", out_data, 32'(i * 3));
    end

    // Scratch-only stores never decide.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      store(32'd80, $urandom, 1'($urandom_range(0, 1)));
      chk("t5_done", 32'(done), 32'd0);
    end

    // Unknown address is a failure.
    do_reset();
    store('x, 32'd7, 1'b0);
    chk("tx_fail", 32'(fail), 32'd1);

    // Asynchronous reset between edges.
    do_reset();
    store(32'd80, 32'd1, 1'b0);
    store(32'd84, 32'd7, 1'b0);
    store(32'd12, 32'd3, 1'b0);
    store(32'd13, 32'd4, 1'b0);
    chk("t6_pre_pass", 32'(pass), 32'd1);
    chk("t6_pre_count", 32'(count), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_addr", out_addr, 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_pass", 32'(pass), 32'd0);
    chk("t6_fail", 32'(fail), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    store(32'd84, 32'd7, 1'b0);
    chk("t6_repass", 32'(pass), 32'd1);
    chk("t6_recount", 32'(count), 32'd1);
    chk("t6_rehead", out_addr, 32'd84);

    // Randomized traffic with periodic resets.
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) do_reset();
      sel = $urandom_range(0, 9);
      ra  = (sel < 6) ? 32'd80 : (sel < 7) ? 32'd84 : 32'($urandom_range(0, 127));
      rd  = $urandom_range(0, 1) ? 32'd7 : $urandom;
      mem_write  = 1'($urandom_range(0, 3) != 0);
      data_addr  = ra;
      write_data = rd;
      out_ready  = 1'($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    mem_write = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
